// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers with tick strobes.
// Each channel counts 0..active_div, toggles clk_out and pulses tick at the
// terminal count. Divisor writes land in a shadow register and are promoted at
// the next terminal count, so a running clock never sees a runt pulse.
// Optional feature macro: CLKDIV_SYNC_EN adds sync_in, which phase-aligns all
// channels and promotes shadow divisors immediately.

module clk_div_ch #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(1349)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             clk_q,    clk_d;
    logic             tick_q,   tick_d;

    // Next-state: sync beats enable, enable beats terminal count.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = wr ? wr_div : shadow_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
`ifdef CLKDIV_SYNC_EN
        if (sync) begin
            // A write in the sync cycle takes effect on both registers.
            cnt_d    = '0;
            clk_d    = 1'b0;
            active_d = wr ? wr_div : shadow_q;
        end else
`endif
        if (!en) begin
            // Idle channel: nothing to glitch, so promote the divisor now.
            cnt_d    = '0;
            clk_d    = 1'b0;
            active_d = wr ? wr_div : shadow_q;
        end else if (cnt_q == active_q) begin
            // shadow_q (not shadow_d): a same-cycle write waits one more period.
            cnt_d    = '0;
            tick_d   = 1'b1;
            clk_d    = ~clk_q;
            active_d = shadow_q;
        end else begin
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            active_q <= DIV_DEFAULT;
            shadow_q <= DIV_DEFAULT;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

module clk_div_multi #(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = 16,
    parameter  int DIV_DEFAULT = 1349,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // Addresses >= NUM_CH match no channel, so such writes fall on the floor.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (CNT_W'(DIV_DEFAULT))
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (ch_en[i]),
            .wr      (wr),
            .wr_div  (cfg_div),
`ifdef CLKDIV_SYNC_EN
            .sync    (sync_in),
`endif
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi. Stimulus pushes expected tick events
// (cycle + clk_out level) per channel and expected output samples; a monitor
// checks them one time unit after every rising edge.
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              sync_in;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_DEFAULT(1349)) dut (
        .clk     (clk),
        .reset   (reset),
        .ch_en   (ch_en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
`ifdef CLKDIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .clk_out (clk_out),
        .tick    (tick)
    );

    typedef struct { int cyc; logic clk; } tick_e;
    typedef struct { int cyc; int ch; logic clk; logic tk; } smp_e;

    tick_e             tq[NUM_CH][$];
    smp_e              sq[$];
    logic [NUM_CH-1:0] mon_en;
    int                cyc;
    int                nvec;
    int                nerr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples due this cycle, then tick events per channel.
    initial begin
        smp_e  s;
        tick_e e;
        forever begin
            @(posedge clk);
            #1;
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                s = sq.pop_front();
                nvec++;
                if (s.cyc < cyc) begin
                    nerr++;
                    $display("FAIL sample_late ch%0d cyc %0d: not checked at due cycle", s.ch, s.cyc);
                end else if (clk_out[s.ch] !== s.clk || tick[s.ch] !== s.tk) begin
                    nerr++;
                    $display("FAIL sample ch%0d cyc %0d: got clk_out=%b tick=%b, want clk_out=%b tick=%b",
                             s.ch, cyc, clk_out[s.ch], tick[s.ch], s.clk, s.tk);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (mon_en[i]) begin
                    while (tq[i].size() > 0 && tq[i][0].cyc < cyc) begin
                        e = tq[i].pop_front();
                        nvec++;
                        nerr++;
                        $display("FAIL missing_tick ch%0d: none at cyc %0d, want tick there", i, e.cyc);
                    end
                    if (tick[i] === 1'b1) begin
                        nvec++;
                        if (tq[i].size() == 0 || tq[i][0].cyc != cyc) begin
                            nerr++;
                            $display("FAIL extra_tick ch%0d: got tick at cyc %0d, want none", i, cyc);
                        end else begin
                            e = tq[i].pop_front();
                            if (clk_out[i] !== e.clk) begin
                                nerr++;
                                $display("FAIL tick_clk ch%0d cyc %0d: got clk_out=%b, want %b",
                                         i, cyc, clk_out[i], e.clk);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_ticks(input int ch, input int first, input int period,
                              input int n, input logic clk1);
        tick_e e;
        for (int k = 0; k < n; k++) begin
            e.cyc = first + k * period;
            e.clk = (k % 2 == 0) ? clk1 : ~clk1;
            tq[ch].push_back(e);
        end
    endtask

    task automatic push_smp(input int c, input int ch, input logic ck, input logic tk);
        smp_e s;
        s.cyc = c; s.ch = ch; s.clk = ck; s.tk = tk;
        sq.push_back(s);
    endtask

    task automatic close_ch(input int ch);
        tick_e e;
        mon_en[ch] = 1'b0;
        while (tq[ch].size() > 0) begin
            e = tq[ch].pop_front();
            nvec++;
            nerr++;
            $display("FAIL missing_tick ch%0d: none at cyc %0d, want tick there", ch, e.cyc);
        end
    endtask

    initial begin
        int c0, p, q, r, s;
        cyc = 0; nvec = 0; nerr = 0; mon_en = '0;
        reset = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; sync_in = 1'b0;

        // Reset held: everything low.
        push_smp(2, 0, 1'b0, 1'b0);
        push_smp(2, 1, 1'b0, 1'b0);
        wait_cyc(3);
        reset = 1'b1;

        // Defaults: tick every 1350, clk_out 1350 high / 1350 low.
        c0 = 5;
        wait_cyc(c0);
        ch_en = 3'b011;
        push_smp(c0 + 10,   2, 1'b0, 1'b0);
        push_smp(c0 + 1349, 0, 1'b0, 1'b0);
        push_smp(c0 + 1350, 0, 1'b1, 1'b1);
        push_smp(c0 + 2699, 0, 1'b1, 1'b0);
        push_smp(c0 + 2700, 0, 1'b0, 1'b1);
        push_ticks(0, c0 + 1350, 1350, 4, 1'b1);
        push_ticks(1, c0 + 1350, 1350, 4, 1'b1);
        mon_en[1:0] = 2'b11;

        // Mid-period write div=9 to ch1: old period completes first.
        wait_cyc(c0 + 4550);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9;
        push_ticks(1, c0 + 5410, 10, 9, 1'b1);
        wait_cyc(c0 + 4551);
        cfg_we = 1'b0;

        // div=0 on ch0 (loaded while disabled), then an out-of-range write.
        p = c0 + 5450;
        wait_cyc(p);
        close_ch(0);
        ch_en = 3'b010;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0;
        push_smp(p + 1, 0, 1'b0, 1'b0);
        push_smp(p + 2, 0, 1'b0, 1'b0);
        push_ticks(0, p + 3, 1, 10, 1'b1);
        mon_en[0] = 1'b1;
        wait_cyc(p + 1);
        cfg_ch = 2'd3; cfg_div = 16'd2;
        wait_cyc(p + 2);
        cfg_we = 1'b0;
        ch_en = 3'b011;
        wait_cyc(p + 12);
        close_ch(0);
        wait_cyc(c0 + 5495);
        close_ch(1);

        // ch0 div=4: disabled 5 cycles, first tick 5 cycles after re-enable.
        q = c0 + 5500;
        wait_cyc(q);
        ch_en = 3'b010;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
        for (int k = 1; k <= 5; k++) push_smp(q + k, 0, 1'b0, 1'b0);
        push_smp(q + 9, 0, 1'b0, 1'b0);
        push_ticks(0, q + 10, 5, 5, 1'b1);
        mon_en[0] = 1'b1;
        wait_cyc(q + 1);
        cfg_we = 1'b0;
        wait_cyc(q + 5);
        ch_en = 3'b011;

        // Async reset mid-period with clk_out[0] high; divisors revert.
        r = q + 32;
        wait_cyc(r);
        close_ch(0);
        reset = 1'b0;
        #1;
        nvec++;
        if (clk_out !== '0 || tick !== '0) begin
            nerr++;
            $display("FAIL async_reset: got clk_out=%b tick=%b, want 000 000", clk_out, tick);
        end
        push_smp(r + 1, 0, 1'b0, 1'b0);
        push_smp(r + 1, 1, 1'b0, 1'b0);
        push_smp(r + 2, 0, 1'b0, 1'b0);
        push_smp(r + 2, 1, 1'b0, 1'b0);
        wait_cyc(r + 3);
        reset = 1'b1;
        push_smp(r + 1352, 0, 1'b0, 1'b0);
        push_ticks(0, r + 1353, 1350, 2, 1'b1);
        push_ticks(1, r + 1353, 1350, 2, 1'b1);
        mon_en[1:0] = 2'b11;
        wait_cyc(r + 2703);
        close_ch(0);
        close_ch(1);

`ifdef CLKDIV_SYNC_EN
        // Sync with same-cycle writes: ch0 div 3, ch1 div 7, aligned afterwards.
        s = r + 2710;
        wait_cyc(s);
        sync_in = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
        push_smp(s + 1, 0, 1'b0, 1'b0);
        push_smp(s + 1, 1, 1'b0, 1'b0);
        push_smp(s + 2, 0, 1'b0, 1'b0);
        push_smp(s + 2, 1, 1'b0, 1'b0);
        push_ticks(0, s + 6, 4, 8, 1'b1);
        push_ticks(1, s + 10, 8, 4, 1'b1);
        mon_en[1:0] = 2'b11;
        wait_cyc(s + 1);
        cfg_ch = 2'd1; cfg_div = 16'd7;
        wait_cyc(s + 2);
        sync_in = 1'b0; cfg_we = 1'b0;
        wait_cyc(s + 34);
        close_ch(0);
        close_ch(1);
`else
        s = r + 2710;
        wait_cyc(s);
`endif

        wait_cyc(cyc + 2);
        if (sq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL samples_left: got %0d unchecked, want 0", sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
